// File: rtl/stat_pkg.sv
// ============================================================================
//  Module  : stat_pkg
//  Desc    : Shared constants and state encoding for the statistical calculator.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package stat_pkg;

   localparam int DATA_W = 4;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FIRST   = 3'd1;
   localparam logic [2:0] S_ACCEPT  = 3'd2;
   localparam logic [2:0] S_CMP_MAX = 3'd3;
   localparam logic [2:0] S_CMP_MIN = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

endpackage

`default_nettype wire

// File: rtl/comparator.sv
// ============================================================================
//  Module  : comparator
//  Desc    : 4-bit unsigned magnitude comparator (greater / equal / less).
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module comparator
   import stat_pkg::*;
(
   input  logic [DATA_W-1:0] in1,
   input  logic [DATA_W-1:0] in2,
   output logic              G,
   output logic              EQ,
   output logic              L
);

   assign G  = (in1 >  in2);
   assign EQ = (in1 == in2);
   assign L  = (in1 <  in2);

endmodule

`default_nettype wire

// File: rtl/stat_minmax_tracker.sv
// ============================================================================
//  Module  : stat_minmax_tracker
//  Desc    : Streaming running min/max/count over a burst, sharing one comparator.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module stat_minmax_tracker
   import stat_pkg::*;
#(
   parameter int CNT_W = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic [DATA_W-1:0] max_out,
   output logic [DATA_W-1:0] min_out,
   output logic [CNT_W-1:0]  count_out,
   output logic              busy,
   output logic              done,
   output logic              sat
);

   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

   logic [2:0]        r_state;
   logic [DATA_W-1:0] r_max;
   logic [DATA_W-1:0] r_min;
   logic [CNT_W-1:0]  r_count;
   logic              r_sat;
   logic [DATA_W-1:0] r_samp;
   logic              r_last;

   logic [DATA_W-1:0] w_cmp_b;
   logic              w_g;
   logic              w_eq;
   logic              w_l;
   logic [CNT_W-1:0]  w_count_nxt;

   // Second operand follows state only; outside the compare states it is don't-care.
   assign w_cmp_b     = (r_state == S_CMP_MIN) ? r_min : r_max;
   assign w_count_nxt = r_count + CNT_W'(1);

   comparator u_cmp (
      .in1 (r_samp),
      .in2 (w_cmp_b),
      .G   (w_g),
      .EQ  (w_eq),
      .L   (w_l)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_max   <= '0;
         r_min   <= '0;
         r_count <= '0;
         r_sat   <= 1'b0;
         r_samp  <= '0;
         r_last  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_count <= '0;
                  r_sat   <= 1'b0;
                  r_state <= S_FIRST;
               end
            end
            S_FIRST: begin
               if (in_valid) begin
                  r_max   <= in_data;
                  r_min   <= in_data;
                  r_count <= CNT_W'(1);
                  r_state <= in_last ? S_DONE : S_ACCEPT;
               end
            end
            S_ACCEPT: begin
               if (in_valid) begin
                  r_samp  <= in_data;
                  r_last  <= in_last;
                  r_state <= S_CMP_MAX;
               end
            end
            S_CMP_MAX: begin
               if (w_g && !w_eq) begin
                  r_max <= r_samp;
               end
               r_state <= S_CMP_MIN;
            end
            S_CMP_MIN: begin
               if (w_l) begin
                  r_min <= r_samp;
               end
               r_count <= w_count_nxt;
               // An explicit last wins over saturation, so sat only flags truncation.
               if (r_last) begin
                  r_state <= S_DONE;
               end else if (w_count_nxt == c_cnt_max) begin
                  r_sat   <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_state <= S_ACCEPT;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == S_FIRST) || (r_state == S_ACCEPT);
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE);
   assign max_out   = r_max;
   assign min_out   = r_min;
   assign count_out = r_count;
   assign sat       = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_stat_minmax_tracker.sv
// ============================================================================
//  Module  : tb_stat_minmax_tracker
//  Desc    : Directed self-checking bench for stat_minmax_tracker.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_stat_minmax_tracker;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       in_last;
   logic [3:0] max_out;
   logic [3:0] min_out;
   logic [3:0] count_out;
   logic       busy;
   logic       done;
   logic       sat;

   int checks = 0;
   int errors = 0;

   stat_minmax_tracker #(.CNT_W(4)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .max_out   (max_out),
      .min_out   (min_out),
      .count_out (count_out),
      .busy      (busy),
      .done      (done),
      .sat       (sat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Present a sample, hold it until accepted; returns 1ns after the transfer edge.
   task automatic send(input logic [3:0] d, input logic last);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      chk("send_timeout", 32'(n < 50), 32'd1);
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Cycles from the transfer cycle until done is visible.
   task automatic wait_done(output int n);
      n = 1;
      while (!done && n < 40) begin
         step();
         n++;
      end
   endtask

   initial begin
      int lat;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      step(); step();
      rst = 1'b0;
      step();

      chk("rst_max",   32'(max_out),   32'd0);
      chk("rst_min",   32'(min_out),   32'd0);
      chk("rst_cnt",   32'(count_out), 32'd0);
      chk("rst_busy",  32'(busy),      32'd0);
      chk("rst_ready", 32'(in_ready),  32'd0);
      chk("rst_done",  32'(done),      32'd0);

      // 1: 5,9,2,9,7(last)
      pulse_start();
      chk("t1_ready_first", 32'(in_ready), 32'd1);
      send(4'd5, 1'b0);
      send(4'd9, 1'b0);
      send(4'd2, 1'b0);
      send(4'd9, 1'b0);
      step(); step();
      chk("t1_max_rep9", 32'(max_out),   32'd9);
      chk("t1_cnt4",     32'(count_out), 32'd4);
      send(4'd7, 1'b1);
      wait_done(lat);
      chk("t1_latency", 32'(lat),       32'd3);
      chk("t1_max",     32'(max_out),   32'd9);
      chk("t1_min",     32'(min_out),   32'd2);
      chk("t1_cnt",     32'(count_out), 32'd5);
      chk("t1_sat",     32'(sat),       32'd0);
      step();
      chk("t1_done_1cyc", 32'(done), 32'd0);
      chk("t1_idle",      32'(busy), 32'd0);
      chk("t1_hold_max",  32'(max_out), 32'd9);

      // 2: single sample with last
      pulse_start();
      send(4'd6, 1'b1);
      wait_done(lat);
      chk("t2_latency", 32'(lat),       32'd1);
      chk("t2_max",     32'(max_out),   32'd6);
      chk("t2_min",     32'(min_out),   32'd6);
      chk("t2_cnt",     32'(count_out), 32'd1);
      step();

      // 3: saturation at 15 samples
      pulse_start();
      for (int i = 0; i < 15; i++) send(4'hA, 1'b0);
      wait_done(lat);
      chk("t3_latency", 32'(lat),       32'd3);
      chk("t3_cnt",     32'(count_out), 32'd15);
      chk("t3_sat",     32'(sat),       32'd1);
      chk("t3_max",     32'(max_out),   32'hA);
      chk("t3_min",     32'(min_out),   32'hA);
      in_valid = 1'b1; in_data = 4'h1;
      for (int i = 0; i < 5; i++) step();
      chk("t3_16th_ready", 32'(in_ready),  32'd0);
      chk("t3_16th_cnt",   32'(count_out), 32'd15);
      chk("t3_16th_min",   32'(min_out),   32'hA);
      in_valid = 1'b0;

      // 4: gapped stream, mid-burst start ignored
      pulse_start();
      chk("t4_sat_clr", 32'(sat),       32'd0);
      chk("t4_cnt_clr", 32'(count_out), 32'd0);
      send(4'd3, 1'b0);
      step(); step();
      pulse_start();
      chk("t4_start_busy",  32'(busy),      32'd1);
      chk("t4_start_ready", 32'(in_ready),  32'd1);
      chk("t4_start_cnt",   32'(count_out), 32'd1);
      send(4'd0, 1'b0);
      step(); step();
      send(4'hF, 1'b1);
      wait_done(lat);
      chk("t4_done", 32'(done),      32'd1);
      chk("t4_max",  32'(max_out),   32'hF);
      chk("t4_min",  32'(min_out),   32'd0);
      chk("t4_cnt",  32'(count_out), 32'd3);
      step();

      // 5: reset during CMP_MAX
      pulse_start();
      send(4'd4, 1'b0);
      send(4'd8, 1'b0);
      rst = 1'b1;
      #1;
      chk("t5_rst_max",   32'(max_out),   32'd0);
      chk("t5_rst_min",   32'(min_out),   32'd0);
      chk("t5_rst_cnt",   32'(count_out), 32'd0);
      chk("t5_rst_busy",  32'(busy),      32'd0);
      chk("t5_rst_done",  32'(done),      32'd0);
      chk("t5_rst_ready", 32'(in_ready),  32'd0);
      step();
      rst = 1'b0;
      begin
         int seen = 0;
         for (int i = 0; i < 4; i++) begin
            step();
            if (done) seen++;
         end
         chk("t5_no_done", 32'(seen), 32'd0);
      end
      pulse_start();
      send(4'd1, 1'b1);
      wait_done(lat);
      chk("t5_max", 32'(max_out),   32'd1);
      chk("t5_min", 32'(min_out),   32'd1);
      chk("t5_cnt", 32'(count_out), 32'd1);
      step();

      // 6: no start after reset, valid held high
      rst = 1'b1;
      step();
      rst = 1'b0;
      in_valid = 1'b1; in_data = 4'd7;
      for (int i = 0; i < 4; i++) step();
      chk("t6_ready", 32'(in_ready),  32'd0);
      chk("t6_max",   32'(max_out),   32'd0);
      chk("t6_cnt",   32'(count_out), 32'd0);
      chk("t6_busy",  32'(busy),      32'd0);
      in_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
